byte_word_unpacker: RTL and testbench
=====================================

// Module: byte_word_unpacker
// PURPOSE
// - Receive-side stage on the 8-bit byte channel; sits directly downstream of the 32-bit-to-byte transmitter.
// - Rebuilds each 4-beat burst into one pkg word (fields a,b,c,d) and buffers it in a small FIFO.
// - Emits words on a valid/ready interface to the consumer.
// - Drives free back to the transmitter, so a burst starts only when buffer space is guaranteed.
// PARAMETERS
// DEPTH    2   word FIFO entries, >=1
// N_BEATS  4   bytes per word; fixed by pkg width (4*8=32); other values unsupported
// PORTS
// clk        in   1   single clock, rising edge
// rst        in   1   synchronous, active-low reset
// payload    in   8   byte channel data, sampled when put=1
// put        in   1   byte strobe, one byte per cycle, 4 consecutive cycles per burst
// free       out  1   1 = a full burst can be absorbed
// word       out  32  pkg {a,b,c,d}: a = first byte received, d = last
// word_valid out  1   FIFO head holds a word
// word_ready in   1   consumer accepts head when word_valid&&word_ready
// frame_err  out  1   one-cycle pulse: burst ended short (put fell before beat 4)
// ovf_err    out  1   one-cycle pulse: completed word dropped because FIFO full
// BEHAVIOUR
// - Reset (rst=0 at posedge): FIFO emptied, partial word discarded, FSM->IDLE; word=0, word_valid=0, free=1, frame_err=0, ovf_err=0.
// - Reset overrides everything in the same cycle, including mid-burst or with word_valid&&word_ready.
// - FSM: IDLE, COLLECT; beat counter bcnt 0..3.
//   - IDLE & put: shreg[31:24]<=payload, bcnt<=1, ->COLLECT.
//   - COLLECT & put: shift byte into next lower field, bcnt++.
//   - On beat 4 (bcnt==3 & put): push {shreg[31:8],payload}, bcnt<=0, ->IDLE.
//   - COLLECT & !put: frame_err pulse next cycle, partial discarded, ->IDLE.
// - Back-to-back: put held past beat 4 starts a new burst; the byte in the cycle after beat 4 is beat 1 of the next word.
// - Push/pop:
//   - Push in cycle k -> word_valid=1 in k+1 when FIFO was empty (1-cycle latency).
//   - Pop when word_valid&&word_ready.
//   - Simultaneous push and pop on a full FIFO: both occur, count unchanged, no ovf_err.
//   - Push on a full FIFO with no pop: word dropped, ovf_err pulse next cycle, FIFO contents intact.
// - Output stability: word and word_valid held stable while word_valid && !word_ready.
// - Order: strictly FIFO; pointers wrap modulo DEPTH; count 0..DEPTH.
// - free is registered: free = (count + (state==COLLECT)) < DEPTH, computed from next-state values.
//   - Guarantees that a burst the transmitter commits to after seeing free=1 always fits.
// - Errors never block the datapath; the bytes involved are not recovered.
// TESTING
// - Reset, then bytes 0x00,0x01,0x02,0x3F on put x4 -> next cycle word=0x0001023F, word_valid=1.
// - word_ready=0 with 2 bursts -> both stored, free=0 after second.
//   - Raise ready -> words pop in order; free returns to 1.
// - put high 8 cycles, bytes 0x11..0x88 -> words 0x11223344 then 0x55667788; no frame_err.
// - put high 2 cycles then low -> frame_err pulse once; no word pushed; next full burst decodes correctly.
// - FIFO full, ready=0, force 3rd burst -> ovf_err pulse; FIFO words unchanged.
//   - Repeat with ready=1 on the push cycle -> no ovf_err.
// - rst=0 during beat 3 with FIFO holding 1 word -> next cycle word_valid=0, free=1, new burst decodes cleanly.

Source files
------------

// File: rtl/byte_word_unpacker.sv
// Byte-to-word unpacker: rebuilds 4-beat byte bursts into 32-bit words {a,b,c,d},
// buffers them in a small FIFO and tells the transmitter when a full burst fits.
module byte_word_unpacker #(
   parameter int DEPTH   = 2,
   parameter int N_BEATS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  payload,
   input  logic        put,
   output logic        free,
   output logic [31:0] word,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        ovf_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] d;
   } word_t;

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [2:0][7:0]  shreg_q, shreg_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic             free_q, free_d;
   logic             frame_err_q, frame_err_d;
   logic             ovf_err_q, ovf_err_d;

   logic             push, push_ok, pop;
   word_t            push_word;
   logic [CW:0]      occupancy;
   word_t            mem [DEPTH];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Beat assembly: field a is the first byte, the final beat bypasses the register.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      shreg_d     = shreg_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (put) begin
               shreg_d[2] = payload;
               bcnt_d     = 2'd1;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            if (!put) begin
               frame_err_d = 1'b1;
               bcnt_d      = '0;
               state_d     = IDLE;
            end else if (bcnt_q == 2'(N_BEATS - 1)) begin
               push    = 1'b1;
               bcnt_d  = '0;
               state_d = IDLE;
            end else begin
               shreg_d[2'd2 - bcnt_q] = payload;
               bcnt_d                 = bcnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign push_word  = {shreg_q, payload};
   assign word_valid = (count_q != '0);
   assign pop        = word_valid && word_ready;

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   always_comb begin
      push_ok   = push && ((count_q != CW'(DEPTH)) || pop);
      ovf_err_d = push && !push_ok;
      count_d   = count_q + CW'(push_ok) - CW'(pop);
      wr_ptr_d  = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
      occupancy = {1'b0, count_d} + (CW + 1)'(state_d == COLLECT);
      free_d    = occupancy < (CW + 1)'(DEPTH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         free_q      <= 1'b1;
         frame_err_q <= 1'b0;
         ovf_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         shreg_q     <= shreg_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         free_q      <= free_d;
         frame_err_q <= frame_err_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count gates every read, and word is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (rst && push_ok) begin
         mem[wr_ptr_q] <= push_word;
      end
   end

   assign word      = word_valid ? mem[rd_ptr_q] : '0;
   assign free      = free_q;
   assign frame_err = frame_err_q;
   assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_byte_word_unpacker.sv
// Randomised and directed bench for byte_word_unpacker: a byte-list reference model
// predicts words and flags, a separate monitor checks every handshake against a scoreboard.
module tb_byte_word_unpacker;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  payload;
   logic        put;
   logic        free;
   logic [31:0] word;
   logic        word_valid;
   logic        word_ready;
   logic        frame_err;
   logic        ovf_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q [$];
   logic [31:0] fifo_m [$];
   logic [7:0]  cur_m [$];
   logic        exp_free  = 1'b1;
   logic        exp_frame = 1'b0;
   logic        exp_ovf   = 1'b0;

   byte_word_unpacker #(.DEPTH(DEPTH), .N_BEATS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .payload    (payload),
      .put        (put),
      .free       (free),
      .word       (word),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_err  (frame_err),
      .ovf_err    (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bursts are byte lists; a word exists once four consecutive bytes arrive.
   initial begin
      logic        pop_m;
      logic [31:0] w;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("word_valid", 32'(word_valid), 32'(fifo_m.size() != 0));
         check("free", 32'(free), 32'(exp_free));
         check("frame_err", 32'(frame_err), 32'(exp_frame));
         check("ovf_err", 32'(ovf_err), 32'(exp_ovf));
         exp_frame = 1'b0;
         exp_ovf   = 1'b0;
         if (!rst) begin
            fifo_m.delete();
            exp_q.delete();
            cur_m.delete();
         end else begin
            pop_m = (fifo_m.size() != 0) && word_ready;
            if (put) begin
               cur_m.push_back(payload);
               if (cur_m.size() == 4) begin
                  w = {cur_m[0], cur_m[1], cur_m[2], cur_m[3]};
                  cur_m.delete();
                  if (fifo_m.size() < DEPTH || pop_m) begin
                     if (pop_m) void'(fifo_m.pop_front());
                     pop_m = 1'b0;
                     fifo_m.push_back(w);
                     exp_q.push_back(w);
                  end else begin
                     exp_ovf = 1'b1;
                  end
               end
            end else if (cur_m.size() != 0) begin
               exp_frame = 1'b1;
               cur_m.delete();
            end
            if (pop_m) void'(fifo_m.pop_front());
         end
         exp_free = (fifo_m.size() + ((cur_m.size() != 0) ? 1 : 0)) < DEPTH;
      end
   end

   // Monitor: every accepted word must match the oldest predicted word; held words must not move.
   initial begin
      logic        hold = 1'b0;
      logic [31:0] held_word = '0;
      logic [31:0] e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst && hold) begin
            check("hold_valid", 32'(word_valid), 32'd1);
            check("hold_word", word, held_word);
         end
         if (rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", word, 32'hDEAD_BEEF ^ word ^ 32'h1);
            end else begin
               e = exp_q.pop_front();
               check("word_data", word, e);
            end
         end
         hold      = rst && word_valid && !word_ready;
         held_word = word;
      end
   end

   task automatic drive(input logic p, input logic [7:0] d, input logic r);
      put        = p;
      payload    = d;
      word_ready = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit(input int mode);
      return (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
   endfunction

   task automatic burst(input logic [31:0] w, input int n, input int rmode);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, w[31-8*k -: 8], rbit(rmode));
      end
   endtask

   initial begin
      rst        = 1'b0;
      put        = 1'b0;
      payload    = '0;
      word_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_word", word, 32'h0);
      check("reset_valid", 32'(word_valid), 32'd0);
      check("reset_free", 32'(free), 32'd1);
      rst = 1'b1;

      // First burst decodes with one cycle of latency.
      burst(32'h0001023F, 4, 0);
      check("first_valid", 32'(word_valid), 32'd1);
      check("first_word", word, 32'h0001023F);
      drive(1'b0, 8'h00, 1'b1);

      // Two bursts stall, then drain in order.
      burst(32'hA0A1A2A3, 4, 0);
      drive(1'b0, 8'h00, 1'b0);
      burst(32'hB0B1B2B3, 4, 0);
      check("full_free", 32'(free), 32'd0);
      check("full_head", word, 32'hA0A1A2A3);
      repeat (3) drive(1'b0, 8'h00, 1'b1);
      check("drained_free", 32'(free), 32'd1);

      // Back-to-back bursts.
      burst(32'h11223344, 4, 1);
      burst(32'h55667788, 4, 1);
      check("b2b_frame", 32'(frame_err), 32'd0);
      repeat (2) drive(1'b0, 8'h00, 1'b1);

      // Short burst, then a clean one.
      burst(32'hC0C1C2C3, 2, 1);
      drive(1'b0, 8'h00, 1'b1);
      check("short_frame", 32'(frame_err), 32'd1);
      check("short_nopush", 32'(word_valid), 32'd0);
      drive(1'b0, 8'h00, 1'b1);
      check("short_pulse", 32'(frame_err), 32'd0);
      burst(32'hD0D1D2D3, 4, 0);
      check("after_short", word, 32'hD0D1D2D3);
      drive(1'b0, 8'h00, 1'b1);

      // Overflow on a full FIFO, then the same push with a concurrent pop.
      burst(32'hE0E1E2E3, 4, 0);
      burst(32'hE4E5E6E7, 4, 0);
      burst(32'hE8E9EAEB, 4, 0);
      check("ovf_pulse", 32'(ovf_err), 32'd1);
      check("ovf_head", word, 32'hE0E1E2E3);
      repeat (3) drive(1'b0, 8'h00, 1'b1);
      burst(32'hF0F1F2F3, 4, 0);
      burst(32'hF4F5F6F7, 4, 0);
      burst(32'hF8F9FAFB, 3, 0);
      drive(1'b1, 8'hFE, 1'b1);
      check("nopush_ovf", 32'(ovf_err), 32'd0);
      check("nopush_head", word, 32'hF4F5F6F7);
      repeat (3) drive(1'b0, 8'h00, 1'b1);

      // Reset on beat 3 with one word stored.
      burst(32'h12345678, 4, 0);
      burst(32'h9ABCDEF0, 2, 0);
      rst = 1'b0;
      drive(1'b1, 8'hDE, 1'b1);
      rst = 1'b1;
      check("rst_valid", 32'(word_valid), 32'd0);
      check("rst_free", 32'(free), 32'd1);
      burst(32'h0BADF00D, 4, 0);
      check("post_rst_word", word, 32'h0BADF00D);
      drive(1'b0, 8'h00, 1'b1);

      // Random traffic: mostly polite, sometimes forced, with short bursts mixed in.
      for (int i = 0; i < 500; i++) begin
         if (free || $urandom_range(0, 4) == 0) begin
            burst($urandom, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 4, 2);
         end else begin
            drive(1'b0, 8'($urandom), rbit(2));
         end
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         drive(1'b0, 8'h00, 1'b1);
      end
      check("drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
